// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order writeback
// stage (W) and an out-of-order long-latency unit (iterative MUL/DIV). Keeps a
// scoreboard of outstanding long-latency destinations so decode can stall on
// RAW/WAW hazards. A starvation counter ensures the long-latency unit is
// eventually granted even while W writes every cycle.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reg_write_enW, rdW, resultW W stage write request, destination and data
//   ll_issue, ll_issue_rd       long-latency op dispatched, and its destination
//   ll_valid, ll_rd, ll_data    long-latency result request
//   ll_ready                    long-latency result accepted this cycle
//   rs1D, rs2D, rdD             decode-stage register indices
//   ll_hazard                   decode must stall on a pending destination
//   stall_w                     freeze W and upstream (W lost the port)
//   rf_we, rf_rd, rf_wdata      register-file write port
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write_enW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  input  logic        ll_issue,
  input  logic [4:0]  ll_issue_rd,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rdD,
  output logic        ll_hazard,
  output logic        stall_w,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  logic [31:0] pending_q, pending_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic w_req, l_req, ll_zero, ll_win;

  // Grant and write-port mux. Everything is forced quiet while reset is high.
  always_comb begin
    w_req     = reg_write_enW && (rdW != 5'd0);
    l_req     = ll_valid && (ll_rd != 5'd0);
    // A result targeting x0 needs no port: accept it for free.
    ll_zero   = ll_valid && (ll_rd == 5'd0);
    ll_win    = l_req && (!w_req || (starve_cnt_q == StarveLimit));

    rf_we     = 1'b0;
    rf_rd     = 5'd0;
    rf_wdata  = 32'd0;
    ll_ready  = 1'b0;
    stall_w   = 1'b0;
    ll_hazard = 1'b0;

    if (!reset) begin
      if (ll_win) begin
        rf_we    = 1'b1;
        rf_rd    = ll_rd;
        rf_wdata = ll_data;
      end else if (w_req) begin
        rf_we    = 1'b1;
        rf_rd    = rdW;
        rf_wdata = resultW;
      end
      ll_ready  = ll_win || ll_zero;
      // W lost the port: it holds and retries next cycle.
      stall_w   = ll_win && w_req;
      ll_hazard = pending_q[rs1D] | pending_q[rs2D] | pending_q[rdD];
    end
  end

  // Next-state: starvation counter and scoreboard.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ll_ready) begin
      starve_cnt_d = 4'd0;
    end else if (ll_valid && (starve_cnt_q != StarveLimit)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    pending_d = pending_q;
    if (ll_ready && (ll_rd != 5'd0)) begin
      pending_d[ll_rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue to the same index wins.
    if (ll_issue && (ll_issue_rd != 5'd0)) begin
      pending_d[ll_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 32'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_enW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        ll_hazard;
  logic        stall_w;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .reg_write_enW(reg_write_enW),
    .rdW          (rdW),
    .resultW      (resultW),
    .ll_issue     (ll_issue),
    .ll_issue_rd  (ll_issue_rd),
    .ll_valid     (ll_valid),
    .ll_rd        (ll_rd),
    .ll_data      (ll_data),
    .ll_ready     (ll_ready),
    .rs1D         (rs1D),
    .rs2D         (rs2D),
    .rdD          (rdD),
    .ll_hazard    (ll_hazard),
    .stall_w      (stall_w),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one more time unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; reg_write_enW = 1'b0; rdW = 5'd0; resultW = 32'd0;
    ll_issue = 1'b0; ll_issue_rd = 5'd0; ll_valid = 1'b0; ll_rd = 5'd0;
    ll_data = 32'd0; rs1D = 5'd0; rs2D = 5'd0; rdD = 5'd0;
  endtask

  task automatic do_reset();
    next_cycle(); idle_inputs(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
  endtask

  task automatic test_reset();
    // Active requests during reset must not reach the port or scoreboard.
    next_cycle();
    idle_inputs(); reset = 1'b1;
    reg_write_enW = 1'b1; rdW = 5'd5; resultW = 32'h1111_2222;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h3333_4444;
    ll_issue = 1'b1; ll_issue_rd = 5'd9; rs1D = 5'd9;
    #1;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b exp=0", rf_we); else pass_cnt++;
    total_cnt++; if (ll_ready !== 1'b0) $display("FAIL reset_ll_ready got=%b exp=0", ll_ready); else pass_cnt++;
    total_cnt++; if (stall_w !== 1'b0) $display("FAIL reset_stall_w got=%b exp=0", stall_w); else pass_cnt++;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL reset_hazard got=%b exp=0", ll_hazard); else pass_cnt++;
    next_cycle();
    idle_inputs(); rs1D = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL reset_pending_clear got=%b exp=0", ll_hazard); else pass_cnt++;
    // Mid-operation reset clears a pending destination.
    ll_issue = 1'b1; ll_issue_rd = 5'd9;
    next_cycle();
    idle_inputs(); rs1D = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b1) $display("FAIL pre_reset_pending got=%b exp=1", ll_hazard); else pass_cnt++;
    reset = 1'b1;
    next_cycle();
    idle_inputs(); rs1D = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL midop_reset_clear got=%b exp=0", ll_hazard); else pass_cnt++;
  endtask

  task automatic test_w_write();
    next_cycle();
    idle_inputs();
    reg_write_enW = 1'b1; rdW = 5'd5; resultW = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (rf_we !== 1'b1) $display("FAIL w_rf_we got=%b exp=1", rf_we); else pass_cnt++;
    total_cnt++; if (rf_rd !== 5'd5) $display("FAIL w_rf_rd got=%0d exp=5", rf_rd); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'hDEAD_BEEF) $display("FAIL w_rf_wdata got=%h exp=deadbeef", rf_wdata); else pass_cnt++;
    total_cnt++; if (stall_w !== 1'b0) $display("FAIL w_stall got=%b exp=0", stall_w); else pass_cnt++;
    total_cnt++; if (ll_ready !== 1'b0) $display("FAIL w_ll_ready got=%b exp=0", ll_ready); else pass_cnt++;
    // x0 writes are not requests.
    next_cycle();
    idle_inputs();
    reg_write_enW = 1'b1; rdW = 5'd0; resultW = 32'h5555_5555;
    #1;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL w_x0_rf_we got=%b exp=0", rf_we); else pass_cnt++;
  endtask

  task automatic test_ll_idle_w();
    next_cycle();
    idle_inputs(); ll_issue = 1'b1; ll_issue_rd = 5'd7;
    next_cycle();
    idle_inputs(); rs1D = 5'd7;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h0000_1234;
    #1;
    total_cnt++; if (ll_hazard !== 1'b1) $display("FAIL ll_pending7 got=%b exp=1", ll_hazard); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b1) $display("FAIL ll_rf_we got=%b exp=1", rf_we); else pass_cnt++;
    total_cnt++; if (rf_rd !== 5'd7) $display("FAIL ll_rf_rd got=%0d exp=7", rf_rd); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'h0000_1234) $display("FAIL ll_rf_wdata got=%h exp=00001234", rf_wdata); else pass_cnt++;
    total_cnt++; if (ll_ready !== 1'b1) $display("FAIL ll_ready got=%b exp=1", ll_ready); else pass_cnt++;
    next_cycle();
    idle_inputs(); rs1D = 5'd7;
    #1;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL ll_retired7 got=%b exp=0", ll_hazard); else pass_cnt++;
  endtask

  task automatic test_starvation();
    do_reset();
    for (int i = 1; i <= LIMIT + 1; i++) begin
      next_cycle();
      idle_inputs();
      reg_write_enW = 1'b1; rdW = 5'(i); resultW = 32'h100 + 32'(i);
      ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hCAFE_F00D;
      #1;
      if (i <= LIMIT) begin
        total_cnt++; if (ll_ready !== 1'b0) $display("FAIL starve_denied%0d got=%b exp=0", i, ll_ready); else pass_cnt++;
        total_cnt++; if (rf_rd !== 5'(i)) $display("FAIL starve_w_rd%0d got=%0d exp=%0d", i, rf_rd, i); else pass_cnt++;
      end else begin
        total_cnt++; if (ll_ready !== 1'b1) $display("FAIL starve_grant got=%b exp=1", ll_ready); else pass_cnt++;
        total_cnt++; if (stall_w !== 1'b1) $display("FAIL starve_stall got=%b exp=1", stall_w); else pass_cnt++;
        total_cnt++; if (rf_rd !== 5'd10) $display("FAIL starve_ll_rd got=%0d exp=10", rf_rd); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 32'hCAFE_F00D) $display("FAIL starve_ll_data got=%h exp=cafef00d", rf_wdata); else pass_cnt++;
      end
    end
    // W retries its frozen write, now with LL gone.
    next_cycle();
    idle_inputs();
    reg_write_enW = 1'b1; rdW = 5'(LIMIT + 1); resultW = 32'h100 + 32'(LIMIT + 1);
    #1;
    total_cnt++; if (stall_w !== 1'b0) $display("FAIL starve_retry_stall got=%b exp=0", stall_w); else pass_cnt++;
    total_cnt++; if (rf_rd !== 5'(LIMIT + 1)) $display("FAIL starve_retry_rd got=%0d exp=%0d", rf_rd, LIMIT + 1); else pass_cnt++;
    // Counter was cleared by the grant: a fresh LL request is denied again.
    next_cycle();
    ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'h77;
    #1;
    total_cnt++; if (ll_ready !== 1'b0) $display("FAIL starve_cleared got=%b exp=0", ll_ready); else pass_cnt++;
  endtask

  task automatic test_hazard();
    do_reset();
    next_cycle();
    idle_inputs(); ll_issue = 1'b1; ll_issue_rd = 5'd9; rs2D = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL haz_issue_cycle got=%b exp=0", ll_hazard); else pass_cnt++;
    next_cycle();
    idle_inputs(); rs2D = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b1) $display("FAIL haz_rs2 got=%b exp=1", ll_hazard); else pass_cnt++;
    rs2D = 5'd0; rdD = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b1) $display("FAIL haz_rdD got=%b exp=1", ll_hazard); else pass_cnt++;
    rdD = 5'd8; rs1D = 5'd10;
    #1;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL haz_other got=%b exp=0", ll_hazard); else pass_cnt++;
    next_cycle();
    idle_inputs(); rs2D = 5'd9; ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    #1;
    total_cnt++; if (ll_hazard !== 1'b1) $display("FAIL haz_retire_cycle got=%b exp=1", ll_hazard); else pass_cnt++;
    next_cycle();
    idle_inputs(); rs2D = 5'd9;
    #1;
    total_cnt++; if (ll_hazard !== 1'b0) $display("FAIL haz_after_retire got=%b exp=0", ll_hazard); else pass_cnt++;
  endtask

  task automatic test_zero_rd();
    next_cycle();
    idle_inputs();
    reg_write_enW = 1'b1; rdW = 5'd3; resultW = 32'h3333;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hBAD;
    ll_issue = 1'b1; ll_issue_rd = 5'd12;
    #1;
    total_cnt++; if (ll_ready !== 1'b1) $display("FAIL zero_ll_ready got=%b exp=1", ll_ready); else pass_cnt++;
    total_cnt++; if (rf_rd !== 5'd3) $display("FAIL zero_rf_rd got=%0d exp=3", rf_rd); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'h3333) $display("FAIL zero_rf_wdata got=%h exp=00003333", rf_wdata); else pass_cnt++;
    total_cnt++; if (stall_w !== 1'b0) $display("FAIL zero_stall got=%b exp=0", stall_w); else pass_cnt++;
    // Retire and re-issue x12 together: the new issue keeps it pending.
    next_cycle();
    idle_inputs();
    ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'hC;
    ll_issue = 1'b1; ll_issue_rd = 5'd12;
    #1;
    total_cnt++; if (ll_ready !== 1'b1) $display("FAIL same_retire_ready got=%b exp=1", ll_ready); else pass_cnt++;
    next_cycle();
    idle_inputs(); rs1D = 5'd12;
    #1;
    total_cnt++; if (ll_hazard !== 1'b1) $display("FAIL same_set_wins got=%b exp=1", ll_hazard); else pass_cnt++;
  endtask

  // Randomized traffic against a rule-level reference model.
  task automatic test_random();
    bit          pend [32];
    int          denied;
    bit          ll_hold, w_hold;
    bit          w_req, l_req, ll_win;
    logic        e_we, e_rdy, e_stall, e_haz;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    do_reset();
    foreach (pend[k]) pend[k] = 1'b0;
    denied = 0; ll_hold = 1'b0; w_hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cycle();
      reset = ($urandom_range(0, 99) < 3);
      if (!ll_hold) begin
        ll_valid = ($urandom_range(0, 99) < 50);
        ll_rd = 5'($urandom_range(0, 7));
        ll_data = $urandom;
      end
      if (!w_hold) begin
        reg_write_enW = ($urandom_range(0, 99) < 70);
        rdW = 5'($urandom_range(0, 7));
        resultW = $urandom;
      end
      ll_issue = ($urandom_range(0, 99) < 30);
      ll_issue_rd = 5'($urandom_range(0, 7));
      rs1D = 5'($urandom_range(0, 7));
      rs2D = 5'($urandom_range(0, 7));
      rdD = 5'($urandom_range(0, 7));

      w_req = reg_write_enW && (rdW != 0);
      l_req = ll_valid && (ll_rd != 0);
      ll_win = l_req && (!w_req || denied >= int'(LIMIT));
      if (reset) begin
        e_we = 0; e_rd = 0; e_wd = 0; e_rdy = 0; e_stall = 0; e_haz = 0;
      end else begin
        e_we = ll_win || w_req;
        e_rd = ll_win ? ll_rd : (w_req ? rdW : 5'd0);
        e_wd = ll_win ? ll_data : (w_req ? resultW : 32'd0);
        e_rdy = ll_win || (ll_valid && ll_rd == 0);
        e_stall = ll_win && w_req;
        e_haz = (rs1D != 0 && pend[rs1D]) || (rs2D != 0 && pend[rs2D]) ||
                (rdD != 0 && pend[rdD]);
      end
      #1;
      total_cnt++; if (rf_we !== e_we) $display("FAIL rnd_rf_we cyc=%0d got=%b exp=%b", cyc, rf_we, e_we); else pass_cnt++;
      total_cnt++; if (rf_rd !== e_rd) $display("FAIL rnd_rf_rd cyc=%0d got=%0d exp=%0d", cyc, rf_rd, e_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== e_wd) $display("FAIL rnd_rf_wdata cyc=%0d got=%h exp=%h", cyc, rf_wdata, e_wd); else pass_cnt++;
      total_cnt++; if (ll_ready !== e_rdy) $display("FAIL rnd_ll_ready cyc=%0d got=%b exp=%b", cyc, ll_ready, e_rdy); else pass_cnt++;
      total_cnt++; if (stall_w !== e_stall) $display("FAIL rnd_stall_w cyc=%0d got=%b exp=%b", cyc, stall_w, e_stall); else pass_cnt++;
      total_cnt++; if (ll_hazard !== e_haz) $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, ll_hazard, e_haz); else pass_cnt++;

      // Commit the cycle into the model.
      if (reset) begin
        foreach (pend[k]) pend[k] = 1'b0;
        denied = 0; ll_hold = 1'b0; w_hold = 1'b0;
      end else begin
        if (e_rdy && ll_rd != 0) pend[ll_rd] = 1'b0;
        if (ll_issue && ll_issue_rd != 0) pend[ll_issue_rd] = 1'b1;
        if (e_rdy) denied = 0;
        else if (ll_valid) denied++;
        ll_hold = ll_valid && !e_rdy;
        w_hold = e_stall;
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_w_write();
    test_ll_idle_w();
    test_starvation();
    test_hazard();
    test_zero_rd();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order writeback (W) stage and a long-latency unit (iterative MUL/DIV) that completes out of order. It sits beside the MEM/WB pipeline register and drives the register-file write port directly. It tracks outstanding long-latency destinations in a scoreboard so decode can stall on RAW/WAW hazards. A starvation counter guarantees forward progress for the long-latency unit.

## Interface
- STARVE_LIMIT, 4, number of consecutive denied cycles after which the long-latency unit takes priority (legal 1..15)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- reg_write_enW  in  1  W stage requests a write
- rdW  in  5  W stage destination
- resultW  in  32  W stage write data (already muxed)
- ll_issue  in  1  long-latency op dispatched this cycle
- ll_issue_rd  in  5  its destination
- ll_valid  in  1  long-latency result available
- ll_rd  in  5  result destination
- ll_data  in  32  result data
- ll_ready  out  1  result accepted this cycle
- rs1D, rs2D, rdD  in  5 each  decode-stage source/destination indices
- ll_hazard  out  1  decode must stall
- stall_w  out  1  freeze W stage and everything upstream this cycle
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  32  register-file write data

## Operation
- State: pending[31:1] scoreboard bits (bit 0 hard-wired 0); starve_cnt, 4 bits.
- Effective requests: w_req = reg_write_enW && rdW!=0; l_req = ll_valid && ll_rd!=0.
- ll_valid with ll_rd==0: ll_ready=1 immediately, no port use, no stall.
- Grant (combinational): LL wins if l_req && (!w_req || starve_cnt==STARVE_LIMIT); otherwise W wins if w_req.
- W wins: rf_we=1, rf_rd=rdW, rf_wdata=resultW, ll_ready=0, stall_w=0.
- LL wins: rf_we=1, rf_rd=ll_rd, rf_wdata=ll_data, ll_ready=1; stall_w=w_req (W's write retried next cycle with W frozen).
- No request: rf_we=0, rf_rd=0, rf_wdata=0, ll_ready=0, stall_w=0.
- starve_cnt: cleared on any ll_ready; incremented when ll_valid && !ll_ready; saturates at STARVE_LIMIT; held otherwise.
- Scoreboard: ll_issue && ll_issue_rd!=0 sets pending[ll_issue_rd]; ll_ready && ll_rd!=0 clears pending[ll_rd]. Same index set and clear in one cycle: set wins.
- ll_hazard = pending[rs1D] | pending[rs2D] | pending[rdD] (combinational, index 0 always 0).
- Long-latency unit holds ll_rd/ll_data stable while ll_valid && !ll_ready; the arbiter does not buffer.

## Timing
- Reset: pending=0, starve_cnt=0. While reset is high, rf_we=0, ll_ready=0, stall_w=0, ll_hazard=0 regardless of inputs; no writes occur.
- Reset mid-operation: scoreboard cleared in the same edge; the pending LL result is dropped by the pipeline flush.
- Grant, rf_* and stall_w: zero-cycle (combinational from inputs and current state).
- Scoreboard update visible to ll_hazard the cycle after issue/retire.
- Worst-case LL wait with W writing every cycle: STARVE_LIMIT cycles denied, granted on cycle STARVE_LIMIT+1.
- W is never stalled two cycles in a row by the arbiter (counter cleared on LL grant).

## Test plan
- Reset asserted with ll_valid=1, reg_write_enW=1 -> rf_we=0, ll_ready=0, stall_w=0; after release pending=0.
- W writes x5=0xDEADBEEF, ll_valid=0 -> rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, stall_w=0.
- ll_valid (rd=7, 0x1234) with W idle -> same cycle rf_rd=7, rf_wdata=0x1234, ll_ready=1, pending[7] cleared next cycle.
- W writes every cycle, ll_valid held, STARVE_LIMIT=4 -> ll_ready low 4 cycles, high on cycle 5 with stall_w=1, then W's write completes next cycle.
- ll_issue rd=9, then decode rs2D=9 -> ll_hazard=1 from next cycle until cycle after LL rd=9 retires; rdD=9 also hazards.
- ll_valid with ll_rd=0 while W writes x3 -> ll_ready=1, rf_rd=3, stall_w=0; same-cycle issue and retire of rd=12 -> pending[12]=1.
